// File: rtl/gb_pkg.sv
// rtl/gb_pkg.sv - shared Game Boy bus constants, DMA state type and source-page fold helper
package gb_pkg;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [7:0]  OAM_BYTES    = 8'd160;
    localparam logic [7:0]  OAM_LAST     = OAM_BYTES - 8'd1;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_START,
        DMA_READ,
        DMA_WRITE
    } dma_state_t;

    // Pages E0..FF alias the work RAM at C0..DF (echo RAM), so fold them down.
    function automatic logic [7:0] fold_src(input logic [7:0] src);
        return (src >= 8'hE0) ? (src & 8'hDF) : src;
    endfunction

endpackage

// File: rtl/oam_dma_controller.sv
// rtl/oam_dma_controller.sv - OAM DMA engine and CPU-to-memory bus owner
//
// Ports:
//   clock, reset_n             single clock, asynchronous active-low reset
//   cpu_addr/wren/wdata/rdata  CPU side of the bus
//   mem_addr/wren/wdata/rdata  memory-map side of the bus
//   dma_active                 high whenever the engine is not idle
module oam_dma_controller
    import gb_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int START_DELAY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wren,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_wren,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        dma_active
);

    // The sub-counter times both the START wait and the READ hold.
    localparam logic [1:0] READ_LAST  = 2'(MEM_LATENCY);
    localparam logic [1:0] START_LAST = 2'((START_DELAY > 0) ? START_DELAY - 1 : 0);
    localparam dma_state_t ARM_STATE  = (START_DELAY == 0) ? DMA_READ : DMA_START;

    dma_state_t  state_q, state_d;
    logic [7:0]  src_q, src_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic [1:0]  sub_q, sub_d;

    logic        is_ff46;
    logic        ff46_wr;
    logic [7:0]  src_page;

    assign is_ff46  = (cpu_addr == DMA_REG_ADDR);
    assign ff46_wr  = cpu_wren & is_ff46;
    assign src_page = fold_src(src_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DMA_IDLE;
            src_q   <= 8'h00;
            idx_q   <= 8'h00;
            data_q  <= 8'h00;
            sub_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            sub_q   <= sub_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        idx_d   = idx_q;
        data_d  = data_q;
        sub_d   = sub_q;
        if (ff46_wr) begin
            // Accepted in every state; a write while busy restarts from byte 0
            // and abandons any byte still in flight.
            src_d   = cpu_wdata;
            idx_d   = 8'h00;
            sub_d   = 2'd0;
            state_d = ARM_STATE;
        end else begin
            case (state_q)
                DMA_IDLE: ;
                DMA_START: begin
                    if (sub_q == START_LAST) begin
                        sub_d   = 2'd0;
                        state_d = DMA_READ;
                    end else begin
                        sub_d = sub_q + 2'd1;
                    end
                end
                DMA_READ: begin
                    if (sub_q == READ_LAST) begin
                        data_d  = mem_rdata;
                        sub_d   = 2'd0;
                        state_d = DMA_WRITE;
                    end else begin
                        sub_d = sub_q + 2'd1;
                    end
                end
                DMA_WRITE: begin
                    if (idx_q == OAM_LAST) begin
                        idx_d   = 8'h00;
                        state_d = DMA_IDLE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = DMA_READ;
                    end
                end
            endcase
        end
    end

    // Bus mux is driven from the registered state, so a restart landing on a
    // WRITE cycle still completes that old byte's write.
    always_comb begin
        mem_addr  = OAM_BASE;
        mem_wren  = 1'b0;
        mem_wdata = data_q;
        cpu_rdata = is_ff46 ? src_q : 8'hFF;
        case (state_q)
            DMA_IDLE: begin
                mem_addr  = cpu_addr;
                mem_wren  = cpu_wren & ~is_ff46;
                mem_wdata = cpu_wdata;
                cpu_rdata = is_ff46 ? src_q : mem_rdata;
            end
            DMA_START: ;
            DMA_READ: begin
                mem_addr = {src_page, idx_q};
            end
            DMA_WRITE: begin
                mem_addr = OAM_BASE + {8'h00, idx_q};
                mem_wren = 1'b1;
            end
        endcase
    end

    assign dma_active = (state_q != DMA_IDLE);

endmodule

// File: tb/tb_oam_dma_controller.sv
// tb/tb_oam_dma_controller.sv - directed self-checking bench for oam_dma_controller
module tb_oam_dma_controller;

    logic        clock;
    logic        reset_n;
    logic [15:0] cpu_addr;
    logic        cpu_wren;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic [15:0] mem_addr;
    logic        mem_wren;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        dma_active;

    logic [7:0]  mem [0:65535];

    int n_pass  = 0;
    int n_total = 0;
    int active_cnt = 0;
    int wren_cnt   = 0;
    int stray_wr   = 0;

    oam_dma_controller #(.MEM_LATENCY(1), .START_DELAY(1)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cpu_addr   (cpu_addr),
        .cpu_wren   (cpu_wren),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .mem_addr   (mem_addr),
        .mem_wren   (mem_wren),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .dma_active (dma_active)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous RAM, one cycle read latency.
    always @(posedge clock) begin
        if (mem_wren) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    always @(negedge clock) begin
        if (dma_active) active_cnt++;
        if (mem_wren) wren_cnt++;
        if (dma_active && mem_wren && (mem_addr < 16'hFE00 || mem_addr > 16'hFE9F)) stray_wr++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_wren  = 1'b1;
        cyc();
        cpu_wren  = 1'b0;
        cpu_addr  = 16'h0000;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 700; k++) begin
            if (!dma_active) break;
            cyc();
        end
        check(tag, {15'd0, dma_active}, 16'd0);
    endtask

    // pat: 0 -> i^A5, 1 -> i+30, 2 -> ~i
    function automatic logic [7:0] pattern(input int pat, input int i);
        logic [7:0] b;
        b = 8'(i);
        case (pat)
            0: return b ^ 8'hA5;
            1: return b + 8'h30;
            default: return ~b;
        endcase
    endfunction

    task automatic check_oam(input string tag, input int pat);
        int bad;
        bad = 0;
        for (int i = 0; i < 160; i++)
            if (mem[16'hFE00 + 16'(i)] !== pattern(pat, i)) bad++;
        check(tag, 16'(bad), 16'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wren  = 1'b0;
        cpu_wdata = 8'h00;
        repeat (2) cyc();

        // Reset state and pass-through while held in reset
        check("rst_active", {15'd0, dma_active}, 16'd0);
        cpu_addr = 16'hFF46; #1;
        check("rst_src", {8'd0, cpu_rdata}, 16'h0000);
        cpu_addr = 16'hC000; cpu_wren = 1'b1; #1;
        check("rst_wren_pass", {15'd0, mem_wren}, 16'd1);
        cpu_addr = 16'hFF46; #1;
        check("rst_wren_ff46", {15'd0, mem_wren}, 16'd0);
        cpu_wren = 1'b0; cpu_addr = 16'h0000;
        cyc();
        reset_n = 1'b1;
        cyc();

        // 1: idle pass-through
        wren_cnt = 0;
        cpu_wr(16'hC000, 8'h5A);
        cpu_addr = 16'hC000;
        cyc();
        check("idle_rdata", {8'd0, cpu_rdata}, 16'h005A);
        check("idle_wren_cnt", 16'(wren_cnt), 16'd1);
        check("idle_active", {15'd0, dma_active}, 16'd0);

        // Preload source pages through the pass-through bus
        for (int i = 0; i < 160; i++) cpu_wr(16'hC000 + 16'(i), pattern(0, i));
        for (int i = 0; i < 160; i++) cpu_wr(16'hD000 + 16'(i), pattern(1, i));
        for (int i = 0; i < 160; i++) cpu_wr(16'hD100 + 16'(i), pattern(2, i));

        // 2 + 3: basic DMA with CPU blocking
        wren_cnt = 0; stray_wr = 0;
        cpu_wr(16'hFF46, 8'hC0);
        active_cnt = 0;
        check("dma_active_on", {15'd0, dma_active}, 16'd1);
        check("start_addr", mem_addr, 16'hFE00);
        cyc();
        check("read0_addr", mem_addr, 16'hC000);
        check("read0_wren", {15'd0, mem_wren}, 16'd0);
        cyc();
        check("read0_hold", mem_addr, 16'hC000);
        cyc();
        check("write0_addr", mem_addr, 16'hFE00);
        check("write0_wren", {15'd0, mem_wren}, 16'd1);
        check("write0_data", {8'd0, mem_wdata}, 16'h00A5);
        cyc();
        cpu_addr = 16'hC010; #1;
        check("blk_read", {8'd0, cpu_rdata}, 16'h00FF);
        cpu_addr = 16'hFF46; #1;
        check("blk_ff46", {8'd0, cpu_rdata}, 16'h00C0);
        cpu_wr(16'hD000, 8'h11);
        wait_done("dma2_done");
        check("dma2_cycles", 16'(active_cnt), 16'd481);
        check("dma2_pulses", 16'(wren_cnt), 16'd160);
        check("dma2_stray", 16'(stray_wr), 16'd0);
        check("blk_d000", {8'd0, mem[16'hD000]}, 16'h0030);
        check_oam("oam_c0", 0);

        // 4: restart mid-transfer
        cpu_wr(16'hFF46, 8'hC0);
        repeat (99) cyc();
        cpu_wr(16'hFF46, 8'hD0);
        active_cnt = 0;
        check("rst_start_addr", mem_addr, 16'hFE00);
        cyc();
        check("rst_read0", mem_addr, 16'hD000);
        wait_done("dma4_done");
        check("dma4_cycles", 16'(active_cnt), 16'd481);
        check_oam("oam_d0", 1);

        // 5: echo fold
        cpu_wr(16'hFF46, 8'hF1);
        cpu_addr = 16'hFF46; #1;
        check("echo_src", {8'd0, cpu_rdata}, 16'h00F1);
        cpu_addr = 16'h0000;
        cyc();
        check("echo_read0", mem_addr, 16'hD100);
        wait_done("dma5_done");
        check_oam("oam_d1", 2);

        // 6: asynchronous reset mid-transfer
        cpu_wr(16'hFF46, 8'hC0);
        repeat (199) cyc();
        #2 reset_n = 1'b0;
        #1;
        check("areset_active", {15'd0, dma_active}, 16'd0);
        cpu_addr = 16'hFF46; #1;
        check("areset_src", {8'd0, cpu_rdata}, 16'h0000);
        cpu_addr = 16'h0000;
        cyc();
        reset_n = 1'b1;
        wren_cnt = 0;
        repeat (50) cyc();
        check("areset_no_wren", 16'(wren_cnt), 16'd0);
        check("areset_idle", {15'd0, dma_active}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
